// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// One operand stage, LOGW prefix stages and one sum stage, all stalled together by out_ready.
module ksa_pipe_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned LOGW = $clog2(WIDTH);
  localparam int unsigned NST  = LOGW + 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0_in;
  logic [WIDTH-1:0] carry;

  // Stage 0 holds p/g; stages 1..LOGW hold the prefix tree levels.
  logic             vld [NST];
  logic [WIDTH-1:0] gg  [NST];
  logic [WIDTH-1:0] pp  [NST];
  logic [WIDTH-1:0] ps  [NST];
  logic             cc  [NST];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Operand conditioning; carry-in is folded into bit 0 generate.
  always_comb begin
    b_eff   = in_sub ? ~in_b : in_b;
    c0_in   = in_sub | in_cin;
    p_in    = in_a ^ b_eff;
    g_in    = in_a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & c0_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NST; k++) begin
        vld[k] <= 1'b0;
        gg[k]  <= '0;
        pp[k]  <= '0;
        ps[k]  <= '0;
        cc[k]  <= 1'b0;
      end
    end else if (advance) begin
      vld[0] <= in_valid;
      gg[0]  <= g_in;
      pp[0]  <= p_in;
      ps[0]  <= p_in;
      cc[0]  <= c0_in;
      // Level k combines spans at distance 2^(k-1); low bits keep their P/G.
      for (int unsigned k = 1; k < NST; k++) begin
        vld[k] <= vld[k-1];
        gg[k]  <= gg[k-1] | (pp[k-1] & (gg[k-1] << (1 << (k - 1))));
        pp[k]  <= pp[k-1] & ((pp[k-1] << (1 << (k - 1))) |
                             ((WIDTH'(1) << (1 << (k - 1))) - WIDTH'(1)));
        ps[k]  <= ps[k-1];
        cc[k]  <= cc[k-1];
      end
    end
  end

  assign carry = {gg[LOGW][WIDTH-2:0], cc[LOGW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      out_valid <= vld[LOGW];
      out_sum   <= ps[LOGW] ^ carry;
      out_cout  <= gg[LOGW][WIDTH-1];
      out_ovf   <= carry[WIDTH-1] ^ gg[LOGW][WIDTH-1];
    end
  end

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Bench for ksa_pipe_adder: one instance per legal WIDTH, each checked against
// a plain-arithmetic model with directed corners, stall, mid-flight reset and random traffic.
module tb_ksa_pipe_adder;

  localparam int NW = 4;
  localparam int WL [NW] = '{8, 16, 32, 64};
  localparam int BUDGET = 60000;

  logic clk = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int w, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL w%0d %s: got %0h need %0h", w, nm, act, req);
    end
  endtask

  for (genvar gi = 0; gi < NW; gi++) begin : g
    localparam int W  = WL[gi];
    localparam int LG = $clog2(W);

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_cout;
    logic         out_ovf;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] out_sum;

    int           rmode = 0;
    int           npop = 0;
    int           last_lat = 0;
    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_ovf;
    logic [W+1:0] eq [$];
    int           aq [$];
    logic         prev_stall = 1'b0;
    logic [W+1:0] prev_out;
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         mov;
    logic [W+1:0] want;

    ksa_pipe_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_cin   (in_cin),
      .in_sub   (in_sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_cout (out_cout),
      .out_ovf  (out_ovf)
    );

    // out_ready: 0 = held high, 1 = random, 2 = held low
    always begin
      @(posedge clk);
      #1;
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // Reference model and per-cycle checks.
    always @(negedge clk) begin
      if (!rst_n) begin
        eq.delete();
        aq.delete();
        prev_stall = 1'b0;
        chk("rst_out", W, 128'({out_valid, out_cout, out_ovf, out_sum}), 128'(0));
      end else begin
        chk("in_ready", W, 128'(in_ready), 128'(!out_valid || out_ready));
        if (prev_stall)
          chk("stall_hold", W, 128'({out_valid, out_ovf, out_cout, out_sum}), 128'({1'b1, prev_out}));
        if (in_valid && in_ready) begin
          bb   = in_sub ? ~in_b : in_b;
          full = {1'b0, in_a} + {1'b0, bb} + (W + 1)'(in_sub ? 1'b1 : in_cin);
          mov  = (in_a[W-1] == bb[W-1]) && (full[W-1] != in_a[W-1]);
          eq.push_back({mov, full});
          aq.push_back(cyc);
        end
        if (out_valid && out_ready) begin
          if (eq.size() == 0) begin
            chk("spurious", W, 128'(out_valid), 128'(0));
          end else begin
            want = eq.pop_front();
            chk("result", W, 128'({out_ovf, out_cout, out_sum}), 128'(want));
            last_lat = cyc - aq.pop_front();
            chk("lat_min", W, 128'(last_lat >= LG + 2), 128'(1));
            last_sum  = out_sum;
            last_cout = out_cout;
            last_ovf  = out_ovf;
            npop++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_ovf, out_cout, out_sum};
      end
    end

    function automatic logic [W-1:0] rnd();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return W'(r);
    endfunction

    function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return {1'b0, {(W-1){1'b1}}};
        default: return rnd();
      endcase
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      for (int n = 0; n < 1000; n++) begin
        @(negedge clk);
        if (in_ready) break;
      end
      chk("accept", W, 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    endtask

    task automatic wait_pop(input int target);
      for (int n = 0; n < 2000 && npop < target; n++) begin
        @(posedge clk);
        #2;
      end
      chk("pop_bound", W, 128'(npop >= target), 128'(1));
    endtask

    task automatic check_last(input string nm, input logic [W-1:0] s, input logic c, input logic o);
      chk({nm, "_sum"},  W, 128'(last_sum),  128'(s));
      chk({nm, "_cout"}, W, 128'(last_cout), 128'(c));
      chk({nm, "_ovf"},  W, 128'(last_ovf),  128'(o));
      chk({nm, "_lat"},  W, 128'(last_lat),  128'(LG + 2));
    endtask

    initial begin
      int base;
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", W, 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;

      // Hand-computed corners.
      send('1, W'(1), 1'b0, 1'b0);
      wait_pop(1);
      check_last("wrap", '0, 1'b1, 1'b0);
      send({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0);
      wait_pop(2);
      check_last("posovf", {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
      send(W'(5), W'(7), 1'b1, 1'b1);
      wait_pop(3);
      check_last("sub", {{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0);

      // Ten mixed transactions with a 5-cycle downstream stall mid-stream.
      base = npop;
      fork
        for (int i = 0; i < 10; i++)
          send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        begin
          repeat (LG + 4) @(posedge clk);
          rmode = 2;
          repeat (5) begin
            @(negedge clk);
            chk("stall_ready", W, 128'(in_ready), 128'(0));
          end
          @(posedge clk);
          rmode = 0;
        end
      join
      wait_pop(base + 10);

      // Reset with three transactions in flight.
      for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      base = npop;
      repeat (12) begin
        @(negedge clk);
        chk("no_ghost", W, 128'(out_valid), 128'(0));
      end
      chk("no_ghost_pops", W, 128'(npop), 128'(base));
      @(posedge clk);
      #1;
      send(rnd(), rnd(), 1'b1, 1'b0);
      wait_pop(base + 1);
      chk("post_rst_lat", W, 128'(last_lat), 128'(LG + 2));

      // Random traffic with bubbles and random backpressure.
      rmode = 1;
      for (int i = 0; i < 10000; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end else begin
          send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      rmode = 0;
      for (int n = 0; n < 2000 && eq.size() != 0; n++) begin
        @(posedge clk);
        #2;
      end
      chk("drain", W, 128'(eq.size()), 128'(0));
      done_cnt++;
    end
  end

  initial begin
    for (int n = 0; n < BUDGET && done_cnt < NW; n++) @(posedge clk);
    chk("all_done", 0, 128'(done_cnt), 128'(NW));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ksa_pipe_adder.md
KSA_PIPE_ADDER -- requirements
Module: ksa_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand width; legal values 8, 16, 32, 64 only (power of two).
REQ-002 Derived constant LOGW = log2(WIDTH), the number of Kogge-Stone prefix levels.
REQ-003 Clock, reset and handshake ports:
  - clk  in  1  single clock for the block; all state updates on rising edge.
  - rst_n  in  1  reset; asynchronous, active-low.
  - in_valid  in  1  input operands present.
  - in_ready  out  1  block accepts the input on this cycle.
REQ-004 Operand and mode ports:
  - in_a  in  WIDTH  operand A.
  - in_b  in  WIDTH  operand B.
  - in_cin  in  1  carry-in.
  - in_sub  in  1  mode select: 1 = A - B.
REQ-005 Result ports:
  - out_valid  out  1  result present.
  - out_ready  in  1  downstream accepts the result.
  - out_sum  out  WIDTH  sum or difference.
  - out_cout  out  1  carry-out.
  - out_ovf  out  1  signed overflow.

Function
REQ-006 Transfers: input accepted when in_valid && in_ready; result consumed when out_valid && out_ready.
REQ-007 Effective B and carry-in:
  - in_sub=0: B' = in_b, c0 = in_cin.
  - in_sub=1: B' = ~in_b, c0 = 1; in_cin is ignored.
REQ-008 Stage 0 (registered): p = A ^ B', g = A & B'. Carry-in is folded into bit 0 as g0' = g0 | (p0 & c0). The stage registers p (for the sum), g0' and the remaining g, plus c0.
REQ-009 Prefix stages 1..LOGW (each registered), distance d = 2^(k-1):
  - for i >= d: G_i = G_i | (P_i & G_(i-d)) and P_i = P_i & P_(i-d);
  - for i < d: G_i and P_i pass unchanged;
  - original p and c0 are carried alongside.
REQ-010 Final stage (registered):
  - carries: c_0 = c0, c_i = G_(i-1) for i >= 1;
  - out_sum_i = p_i ^ c_i;
  - out_cout = G_(WIDTH-1);
  - out_ovf = c_(WIDTH-1) ^ out_cout.
REQ-011 Arithmetic: results equal (A + B' + c0) mod 2^WIDTH with carry-out, bit-exact for all operands.
REQ-012 Latency: exactly LOGW+2 clock cycles from input acceptance to out_valid when out_ready stays 1 (32-bit: 7 cycles).
REQ-013 Each pipeline stage holds a valid bit. Bubbles (in_valid=0 while advancing) propagate as invalid slots.
REQ-014 Advance: advance = !out_valid || out_ready. All stages shift by one position only when advance=1; otherwise every stage holds.
REQ-015 in_ready equals advance, combinationally. No combinational path exists from in_valid to in_ready.
REQ-016 Throughput: with out_ready held at 1, one result per cycle, back-to-back.
REQ-017 Stall hold: while out_valid=1 and out_ready=0, out_sum, out_cout and out_ovf stay stable and no input is accepted.
REQ-018 Ordering: results emerge in acceptance order; none is dropped or duplicated under any out_ready pattern.
REQ-019 Mode is tracked per transaction: in_sub travels with its operands, so mixed add/sub streams are legal cycle to cycle.

Reset
REQ-020 While rst_n=0: all stage valid bits clear, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, and in_ready=1 one cycle after release.
REQ-021 Reset asserted mid-operation discards every in-flight transaction; none appears after release.
REQ-022 The first input accepted after reset emerges LOGW+2 cycles later with the correct result.

Verification
REQ-023 WIDTH=32, add: A=0xFFFFFFFF, B=0x00000001, cin=0 -> 7 cycles later sum=0x00000000, cout=1, ovf=0.
REQ-024 WIDTH=32, add: A=0x7FFFFFFF, B=0x00000001 -> sum=0x80000000, cout=0, ovf=1.
REQ-025 WIDTH=32, sub: A=0x00000005, B=0x00000007, in_sub=1, in_cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-026 Stall: stream 10 random adds and subs; hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, outputs frozen, all 10 results in order and matching the reference model.
REQ-027 Reset mid-flight: accept 3 inputs, assert rst_n=0 for 2 cycles, release -> out_valid stays 0 until a new input is accepted and completes 7 cycles later.
REQ-028 Sweep WIDTH in {8, 16, 64} with 10k random vectors and random out_ready -> zero mismatches against the behavioural model, and latency equal to LOGW+2.
